// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem via req/done,
// and hands instruc/seq_PC to decode through a one-entry skid buffer.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_dec,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instruc,
    output logic [15:0] seq_PC,
    output logic        valid,
    output logic        halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic [15:0] instr_q;
    logic [15:0] seq_q;
    logic        valid_q;
    logic [15:0] skid_instr;
    logic [15:0] skid_seq;
    logic        halt_pending;

    logic        consume;
    logic        out_free;
    logic        halt_req;
    logic [15:0] next_addr;
    logic [15:0] target;

    assign consume   = valid_q & ~stall;
    assign out_free  = ~valid_q | ~stall;
    assign halt_req  = halt_dec & ~redirect;
    assign next_addr = req_addr + 16'd2;
    assign target    = redirect_pc & 16'hFFFE;

    assign imem_req  = (state == S_FETCH) || (state == S_SQUASH);
    assign imem_addr = req_addr;
    assign instruc   = valid_q ? instr_q : NOP_INSTR;
    assign seq_PC    = seq_q;
    assign valid     = valid_q;
    assign halted    = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            instr_q      <= NOP_INSTR;
            seq_q        <= 16'h0000;
            valid_q      <= 1'b0;
            skid_instr   <= NOP_INSTR;
            skid_seq     <= 16'h0000;
            halt_pending <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (redirect) begin
                        pc           <= target;
                        valid_q      <= 1'b0;
                        halt_pending <= 1'b0;
                        if (imem_done) begin
                            req_addr <= target;
                        end else begin
                            state <= S_SQUASH;
                        end
                    end else if (halt_req) begin
                        valid_q <= 1'b0;
                        if (imem_done) begin
                            state <= S_HALTED;
                        end else begin
                            halt_pending <= 1'b1;
                            state        <= S_SQUASH;
                        end
                    end else if (imem_done) begin
                        pc       <= next_addr;
                        req_addr <= next_addr;
                        if (out_free) begin
                            instr_q <= imem_rdata;
                            seq_q   <= next_addr;
                            valid_q <= 1'b1;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_seq   <= next_addr;
                            state      <= S_HOLD;
                        end
                    end else if (consume) begin
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        req_addr <= target;
                        valid_q  <= 1'b0;
                        state    <= S_FETCH;
                    end else if (halt_req) begin
                        valid_q <= 1'b0;
                        state   <= S_HALTED;
                    end else if (consume) begin
                        instr_q <= skid_instr;
                        seq_q   <= skid_seq;
                        valid_q <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_SQUASH: begin
                    // old request must run to completion; only the target moves
                    if (redirect) begin
                        pc           <= target;
                        halt_pending <= 1'b0;
                    end else if (halt_req) begin
                        halt_pending <= 1'b1;
                    end
                    if (imem_done) begin
                        req_addr <= redirect ? target : pc;
                        if (!redirect && (halt_pending || halt_req)) begin
                            state <= S_HALTED;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
